row_open_tracker: RTL and testbench
===================================

// Module: row_open_tracker
// PURPOSE
//  Open-row table behind row_open_if (dut side): one entry {open, row} per DRAM bank (bank_group x bank).
//  Classifies each scheduler request as HIT / MISS (bank closed) / CONFLICT (other row open).
//  Holds a MISS/CONFLICT until the scheduler reports ACT (and PRE) done via row_resolve, then records the new open row.
//  Sits between request queue and command generator in the DRAM controller.
// PARAMETERS
//  ROW_BITS   15  row address width (matches dram_pkg::ROW_BITS)
//  BG_BITS    2   bank-group index width
//  BANK_BITS  2   bank-in-group index width; NUM_BANKS = 2**(BG_BITS+BANK_BITS) = 16
// PORTS
//  CLK           in   1          clock, all state updates on rising edge
//  RST           in   1          synchronous reset, active-high
//  req_en        in   1          request valid this cycle
//  refresh       in   1          all-bank refresh issued (all banks precharged)
//  row_resolve   in   1          pending MISS/CONFLICT now activated to requested row
//  bank_group    in   BG_BITS    request bank group
//  bank          in   BANK_BITS  request bank
//  row           in   ROW_BITS   request row
//  row_stat      out  2          00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT (registered)
//  row_conflict  out  ROW_BITS   row currently open in bank on CONFLICT, else 0
//  open_mask     out  NUM_BANKS  per-bank open flag, bit index {bank_group,bank}
// BEHAVIOUR
//  Reset: all entries closed, rows 0; row_stat=00, row_conflict=0, open_mask=0, FSM=READY.
//  Index idx = {bank_group, bank}. Lookup uses table state before any update in the same cycle.
//  FSM states READY, WAIT_RES.
//  READY, req_en=1: next cycle row_stat =
//   HIT (01) if open[idx] && row_tab[idx]==row; row_conflict=0; stay READY.
//   MISS (10) if !open[idx]; row_conflict=0; latch idx,row; go WAIT_RES.
//   CONFLICT (11) if open[idx] && row differs; row_conflict=row_tab[idx]; latch idx,row; go WAIT_RES.
//  READY, req_en=0: next cycle row_stat=00, row_conflict=0. HIT therefore shows one cycle;
//   back-to-back req_en in READY gives one result per cycle, latency 1.
//  WAIT_RES: row_stat and row_conflict held; req_en ignored (scheduler must not issue).
//  WAIT_RES, row_resolve=1: open[lidx]=1, row_tab[lidx]=lrow; next cycle row_stat=00,
//   row_conflict=0, FSM=READY; new req_en accepted from the following cycle.
//  row_resolve in READY: ignored, no table change.
//  refresh=1 (any state, highest priority): next cycle all open bits 0 (row_tab may keep values),
//   row_stat=00, row_conflict=0, FSM=READY; concurrent req_en/row_resolve dropped.
//  RST mid-WAIT_RES: same as reset; pending request discarded.
//  open_mask = open[] registered bits, updated same edge as table write.
//  No per-bank precharge input; bank closes only via refresh or RST.
// TESTING
//  Reset: assert RST 2 cycles -> row_stat=00, row_conflict=0, open_mask=16'h0000.
//  Miss/resolve/hit: req bg=1,bank=2,row=0x1A3 -> next cycle 10; held until row_resolve;
//   then 00, open_mask=16'h0040; same req again -> 01 for one cycle.
//  Conflict: with bank 6 open at 0x1A3, req bg=1,bank=2,row=0x0055 -> 11, row_conflict=0x1A3;
//   row_resolve -> 00; req row=0x0055 -> 01.
//  WAIT_RES isolation: req to bank 0 during pending CONFLICT -> ignored, row_stat stays 11;
//   bank 0 still MISS after resolve.
//  Refresh: banks 0,6,15 open; refresh + req_en same cycle -> 00, open_mask=0; later req to bank 15 -> 10.
//  Back-to-back hits: banks 0,6 open; req bank0, bank6, bank0 on consecutive cycles -> 01,01,01 then 00.

Source files
------------

// File: rtl/row_open_tracker_if.sv
// Scheduler <-> open-row tracker link: request lookup, resolve and refresh strobes, classification result.
interface row_open_if #(
    parameter int ROW_BITS  = 15,
    parameter int BG_BITS   = 2,
    parameter int BANK_BITS = 2
);
    localparam int NUM_BANKS = 1 << (BG_BITS + BANK_BITS);

    logic                 req_en;
    logic                 refresh;
    logic                 row_resolve;
    logic [BG_BITS-1:0]   bank_group;
    logic [BANK_BITS-1:0] bank;
    logic [ROW_BITS-1:0]  row;
    logic [1:0]           row_stat;
    logic [ROW_BITS-1:0]  row_conflict;
    logic [NUM_BANKS-1:0] open_mask;

    modport master (
        output req_en, refresh, row_resolve, bank_group, bank, row,
        input  row_stat, row_conflict, open_mask
    );

    modport slave (
        input  req_en, refresh, row_resolve, bank_group, bank, row,
        output row_stat, row_conflict, open_mask
    );
endinterface

// File: rtl/row_open_tracker.sv
// Per-bank open-row table: classifies requests as HIT/MISS/CONFLICT and records the
// newly activated row once the scheduler resolves a pending MISS/CONFLICT.
module row_open_tracker #(
    parameter int ROW_BITS  = 15,
    parameter int BG_BITS   = 2,
    parameter int BANK_BITS = 2
) (
    input  logic     CLK,
    input  logic     RST,
    row_open_if.slave bus
);
    localparam int IDX_BITS  = BG_BITS + BANK_BITS;
    localparam int NUM_BANKS = 1 << IDX_BITS;

    localparam logic [1:0] STAT_IDLE     = 2'b00;
    localparam logic [1:0] STAT_HIT      = 2'b01;
    localparam logic [1:0] STAT_MISS     = 2'b10;
    localparam logic [1:0] STAT_CONFLICT = 2'b11;

    typedef enum logic [0:0] {ST_READY, ST_WAIT_RES} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_row_stat;
    logic [1:0]            w_row_stat_next;
    logic [ROW_BITS-1:0]   r_row_conflict;
    logic [ROW_BITS-1:0]   w_row_conflict_next;
    logic [IDX_BITS-1:0]   r_lidx;
    logic [ROW_BITS-1:0]   r_lrow;
    logic                  w_latch;
    logic                  w_resolve;
    logic [NUM_BANKS-1:0]  w_wr_mask;
    logic [NUM_BANKS-1:0]  w_open;
    logic [ROW_BITS-1:0]   w_row_tab [NUM_BANKS];
    logic [IDX_BITS-1:0]   w_idx;
    logic [ROW_BITS-1:0]   w_tab_row;
    logic                  w_tab_open;

    assign w_idx      = {bus.bank_group, bus.bank};
    assign w_tab_open = w_open[w_idx];
    assign w_tab_row  = w_row_tab[w_idx];

    // One table entry per bank; refresh clears only the open flag, the stale row is harmless.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic                r_open;
            logic [ROW_BITS-1:0] r_row;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_open <= 1'b0;
                    r_row  <= '0;
                end else if (bus.refresh) begin
                    r_open <= 1'b0;
                end else if (w_wr_mask[gi]) begin
                    r_open <= 1'b1;
                    r_row  <= r_lrow;
                end
            end

            assign w_open[gi]    = r_open;
            assign w_row_tab[gi] = r_row;
        end
    endgenerate

    always_comb begin
        w_state_next        = r_state;
        w_row_stat_next     = r_row_stat;
        w_row_conflict_next = r_row_conflict;
        w_latch             = 1'b0;
        w_resolve           = 1'b0;
        if (bus.refresh) begin
            w_state_next        = ST_READY;
            w_row_stat_next     = STAT_IDLE;
            w_row_conflict_next = '0;
        end else begin
            case (r_state)
                ST_READY: begin
                    w_row_stat_next     = STAT_IDLE;
                    w_row_conflict_next = '0;
                    if (bus.req_en) begin
                        if (!w_tab_open) begin
                            w_row_stat_next = STAT_MISS;
                            w_latch         = 1'b1;
                            w_state_next    = ST_WAIT_RES;
                        end else if (w_tab_row == bus.row) begin
                            w_row_stat_next = STAT_HIT;
                        end else begin
                            w_row_stat_next     = STAT_CONFLICT;
                            w_row_conflict_next = w_tab_row;
                            w_latch             = 1'b1;
                            w_state_next        = ST_WAIT_RES;
                        end
                    end
                end
                ST_WAIT_RES: begin
                    // Result is held and new requests are ignored until the activate is reported.
                    if (bus.row_resolve) begin
                        w_resolve           = 1'b1;
                        w_row_stat_next     = STAT_IDLE;
                        w_row_conflict_next = '0;
                        w_state_next        = ST_READY;
                    end
                end
                default: begin
                    w_state_next        = ST_READY;
                    w_row_stat_next     = STAT_IDLE;
                    w_row_conflict_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_wr_mask = '0;
        if (w_resolve) begin
            w_wr_mask[r_lidx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_READY;
            r_row_stat     <= STAT_IDLE;
            r_row_conflict <= '0;
            r_lidx         <= '0;
            r_lrow         <= '0;
        end else begin
            r_state        <= w_state_next;
            r_row_stat     <= w_row_stat_next;
            r_row_conflict <= w_row_conflict_next;
            if (w_latch) begin
                r_lidx <= w_idx;
                r_lrow <= bus.row;
            end
        end
    end

    assign bus.row_stat     = r_row_stat;
    assign bus.row_conflict = r_row_conflict;
    assign bus.open_mask    = w_open;
endmodule

// File: tb/tb_row_open_tracker.sv
// Scenario bench for row_open_tracker: each step pushes its expected result to a
// scoreboard queue, and the task pops and compares it one cycle after the drive edge.
module tb_row_open_tracker;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    row_open_if #(.ROW_BITS(15), .BG_BITS(2), .BANK_BITS(2)) bus ();

    row_open_tracker #(.ROW_BITS(15), .BG_BITS(2), .BANK_BITS(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        req;
        logic        rfr;
        logic        res;
        logic [1:0]  bg;
        logic [1:0]  bk;
        logic [14:0] row;
        logic [1:0]  stat;
        logic [14:0] conf;
        logic [15:0] mask;
    } stim_t;

    typedef struct {
        logic [1:0]  stat;
        logic [14:0] conf;
        logic [15:0] mask;
    } exp_t;

    exp_t exp_q[$];

    function automatic stim_t mk(logic rst, logic req, logic rfr, logic res,
                                 logic [1:0] bg, logic [1:0] bk, logic [14:0] row,
                                 logic [1:0] stat, logic [14:0] conf, logic [15:0] mask);
        stim_t s;
        s.rst = rst; s.req = req; s.rfr = rfr; s.res = res;
        s.bg = bg; s.bk = bk; s.row = row;
        s.stat = stat; s.conf = conf; s.mask = mask;
        return s;
    endfunction

    // Drives one cycle of stimulus, records the expected outcome, and advances past the edge.
    task automatic apply(input stim_t s);
        exp_t e;
        RST             = s.rst;
        bus.req_en      = s.req;
        bus.refresh     = s.rfr;
        bus.row_resolve = s.res;
        bus.bank_group  = s.bg;
        bus.bank        = s.bk;
        bus.row         = s.row;
        e.stat = s.stat; e.conf = s.conf; e.mask = s.mask;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(1, 0, 0, 0, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(1, 1, 0, 1, 1, 2, 15'h1A3, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0000));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("reset[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL reset[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    task automatic test_miss_resolve_hit();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0040));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b01, 15'h0, 16'h0040));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0040));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("miss_hit[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL miss_hit[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    task automatic test_conflict();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h0055, 2'b11, 15'h1A3, 16'h0040));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b11, 15'h1A3, 16'h0040));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0040));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h0055, 2'b01, 15'h0, 16'h0040));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b11, 15'h0055, 16'h0040));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("conflict[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL conflict[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    // Entered with a CONFLICT pending on bank 6 (open 0x0055, requested 0x1A3).
    task automatic test_wait_isolation();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15'h0007, 2'b11, 15'h0055, 16'h0040));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0040));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15'h0007, 2'b10, 15'h0, 16'h0040));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0041));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b01, 15'h0, 16'h0041));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0041));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("isolation[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL isolation[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    task automatic test_refresh();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 3, 3, 15'h7FFF, 2'b10, 15'h0, 16'h0041));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h8041));
        t.push_back(mk(0, 1, 0, 0, 3, 3, 15'h7FFF, 2'b01, 15'h0, 16'h8041));
        t.push_back(mk(0, 1, 1, 0, 1, 2, 15'h0100, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(0, 1, 0, 0, 3, 3, 15'h7FFF, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 1, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(0, 1, 0, 0, 3, 3, 15'h7FFF, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h8000));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("refresh[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL refresh[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15'h0007, 2'b10, 15'h0, 16'h8000));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h8001));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b10, 15'h0, 16'h8001));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h8041));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15'h0007, 2'b01, 15'h0, 16'h8041));
        t.push_back(mk(0, 1, 0, 0, 1, 2, 15'h1A3, 2'b01, 15'h0, 16'h8041));
        t.push_back(mk(0, 1, 0, 0, 0, 0, 15'h0007, 2'b01, 15'h0, 16'h8041));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 15'h0, 2'b00, 15'h0, 16'h8041));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("b2b[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL b2b[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    // Reset while a MISS is pending must drop it: a later resolve has nothing to commit.
    task automatic test_reset_mid_wait();
        stim_t t[$];
        exp_t  e;
        t.push_back(mk(0, 1, 0, 0, 0, 3, 15'h0123, 2'b10, 15'h0, 16'h8041));
        t.push_back(mk(1, 0, 0, 0, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0000));
        t.push_back(mk(0, 1, 0, 0, 0, 3, 15'h0123, 2'b10, 15'h0, 16'h0000));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 15'h0, 2'b00, 15'h0, 16'h0008));
        foreach (t[i]) begin
            apply(t[i]);
            e = exp_q.pop_front();
            n_checks++;
            $display("rst_mid[%0d] stat=%b conf=%h mask=%h", i, bus.row_stat, bus.row_conflict, bus.open_mask);
            if ({bus.row_stat, bus.row_conflict, bus.open_mask} !== {e.stat, e.conf, e.mask}) begin
                n_errors++;
                $display("FAIL rst_mid[%0d]: got stat=%b conf=%h mask=%h, want stat=%b conf=%h mask=%h",
                         i, bus.row_stat, bus.row_conflict, bus.open_mask, e.stat, e.conf, e.mask);
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        RST             = 1'b1;
        bus.req_en      = 1'b0;
        bus.refresh     = 1'b0;
        bus.row_resolve = 1'b0;
        bus.bank_group  = '0;
        bus.bank        = '0;
        bus.row         = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_miss_resolve_hit();
        test_conflict();
        test_wait_isolation();
        test_refresh();
        test_back_to_back();
        test_reset_mid_wait();
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
